// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of one shared,
// variable-latency memory. Data wins ties, but instruction fetch can only be
// passed over STARVE_LIMIT times in a row. A hung memory is released after
// TIMEOUT_CYC wait cycles with an error completion.
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT_CYC  = 256
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              programming_done,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_rd_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              err,
   output logic              mem_en,
   output logic              mem_rd_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D, RESP} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [SW-1:0] starve_cnt;
   logic [TW-1:0] timer;
   logic          resp_d;     // current transaction belongs to the data port
   logic          resp_err;   // current transaction ended by timeout
   logic          grant_i;
   logic          grant_d;
   logic          in_wait;
   logic          accept;
   logic          expire;

   assign in_wait = (state == WAIT_I) || (state == WAIT_D);
   assign accept  = in_wait && mem_ready;
   assign expire  = in_wait && !mem_ready && (timer == TIMER_LAST);

   // Arbitration: requests are only looked at in IDLE once memory is loaded.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state == IDLE && programming_done) begin
         if (d_req && !(i_req && starve_cnt == STARVE_MAX)) begin
            grant_d = 1'b1;
         end else if (i_req) begin
            grant_i = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_d) begin
               state_nxt = WAIT_D;
            end else if (grant_i) begin
               state_nxt = WAIT_I;
            end
         end
         WAIT_I, WAIT_D: begin
            if (accept || expire) begin
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Completion strobes and status decoded from the state.
   always_comb begin
      busy    = (state != IDLE);
      i_ready = (state == RESP) && !resp_d;
      d_ready = (state == RESP) && resp_d;
      err     = (state == RESP) && resp_err;
   end

   // Starvation counter and wait timer.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= '0;
         timer      <= '0;
      end else begin
         if (grant_i) begin
            starve_cnt <= '0;
         end else if (grant_d && i_req && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SW'(1);
         end
         if (in_wait) begin
            timer <= timer + TW'(1);
         end else begin
            timer <= '0;
         end
      end
   end

   // Issue side: one-cycle enable, request fields captured at grant and held.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_en    <= 1'b0;
         mem_rd_wr <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         resp_d    <= 1'b0;
      end else begin
         mem_en <= grant_i || grant_d;
         if (grant_d) begin
            mem_rd_wr <= d_rd_wr;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            resp_d    <= 1'b1;
         end else if (grant_i) begin
            mem_rd_wr <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            resp_d    <= 1'b0;
         end
      end
   end

   // Completion side: capture read data (zero for writes and timeouts).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         i_rdata  <= '0;
         d_rdata  <= '0;
         resp_err <= 1'b0;
      end else if (accept) begin
         resp_err <= 1'b0;
         if (resp_d) begin
            d_rdata <= mem_rd_wr ? '0 : mem_rdata;
         end else begin
            i_rdata <= mem_rdata;
         end
      end else if (expire) begin
         resp_err <= 1'b1;
         if (resp_d) begin
            d_rdata <= '0;
         end else begin
            i_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transactions, a transaction-level model
// checked every cycle, and literal expectations for the key scenarios.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SL = 4;
   localparam int TO = 256;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          programming_done = 1'b0;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic          i_ready;
   logic [DW-1:0] i_rdata;
   logic          d_req = 1'b0;
   logic          d_rd_wr = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_ready;
   logic [DW-1:0] d_rdata;
   logic          err;
   logic          mem_en;
   logic          mem_rd_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata = '0;
   logic          busy;

   logic          mem_rdy_auto = 1'b0;
   logic          mem_rdy_man = 1'b0;
   assign mem_ready = mem_rdy_auto | mem_rdy_man;

   int            n_checks = 0;
   int            n_errs = 0;
   int            cyc = 0;
   int            mem_lat = -1;
   logic [DW-1:0] mem_data = '0;
   bit            glog[$];

   // model of the outstanding transaction
   bit            m_act = 0;
   bit            m_isd = 0;
   bit            m_got = 0;
   int            m_iss = 0;
   int            m_done = 0;
   logic [AW-1:0] m_addr = '0;
   bit            m_wr = 0;
   logic [DW-1:0] m_wd = '0;
   logic [DW-1:0] m_erd = '0;
   bit            m_err = 0;
   int            m_starve = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .resetn(resetn), .programming_done(programming_done),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_req(d_req), .d_rd_wr(d_rd_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata), .err(err),
      .mem_en(mem_en), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
      end
   endtask

   // Memory: answers mem_lat cycles after mem_en (0 = same cycle, -1 = never).
   initial begin
      int left;
      bit pend;
      left = 0;
      pend = 0;
      forever begin
         @(posedge clk);
         #2;
         mem_rdy_auto = 1'b0;
         if (!resetn) begin
            pend = 0;
         end else begin
            if (mem_en) begin
               pend = 1;
               left = mem_lat;
            end
            if (pend && mem_lat >= 0) begin
               if (left == 0) begin
                  mem_rdy_auto = 1'b1;
                  mem_rdata = mem_data;
                  pend = 0;
               end else begin
                  left--;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the transaction model.
   initial begin
      bit e_busy, e_en, e_ir, e_dr;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            chk("reset_outputs",
                {10'd0, mem_en, i_ready, d_ready, err, busy, mem_rd_wr,
                 |mem_addr, |mem_wdata, |i_rdata, |d_rdata, 12'd0}, 32'd0);
            m_act = 0;
            m_starve = 0;
            m_got = 0;
         end else begin
            e_busy = m_act && cyc >= m_iss;
            e_en   = m_act && cyc == m_iss;
            e_ir   = m_act && cyc == m_done && !m_isd;
            e_dr   = m_act && cyc == m_done && m_isd;
            chk("busy", 32'(busy), 32'(e_busy));
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("i_ready", 32'(i_ready), 32'(e_ir));
            chk("d_ready", 32'(d_ready), 32'(e_dr));
            if (m_act && cyc >= m_iss && cyc < m_done) begin
               chk("mem_addr", mem_addr, m_addr);
               chk("mem_rd_wr", 32'(mem_rd_wr), 32'(m_wr));
               if (m_isd) chk("mem_wdata", mem_wdata, m_wd);
            end
            if (e_ir) begin
               chk("i_rdata", i_rdata, m_erd);
               chk("err_i", 32'(err), 32'(m_err));
            end else if (e_dr) begin
               chk("d_rdata", d_rdata, m_erd);
               chk("err_d", 32'(err), 32'(m_err));
            end else begin
               chk("err_idle", 32'(err), 32'd0);
            end
            if (mem_en) glog.push_back(mem_addr == 32'h2000);
            // advance the model with this cycle's inputs
            if (m_act) begin
               if (cyc >= m_iss && cyc < m_done && !m_got && mem_ready) begin
                  m_got  = 1;
                  m_done = cyc + 1;
                  m_erd  = m_wr ? '0 : mem_rdata;
                  m_err  = 0;
               end
               if (cyc == m_done) m_act = 0;
            end else if (programming_done && (i_req || d_req)) begin
               m_isd = d_req && !(i_req && m_starve == SL);
               if (m_isd) begin
                  if (i_req && m_starve < SL) m_starve++;
               end else begin
                  m_starve = 0;
               end
               m_act  = 1;
               m_got  = 0;
               m_iss  = cyc + 1;
               m_done = cyc + 1 + TO;
               m_erd  = '0;
               m_err  = 1;
               m_addr = m_isd ? d_addr : i_addr;
               m_wr   = m_isd ? d_rd_wr : 1'b0;
               m_wd   = d_wdata;
            end
         end
      end
   end

   task automatic wait_en(input int budget, output int at, output logic [AW-1:0] a,
                          output logic rw, output logic [DW-1:0] wd);
      bit ok;
      ok = 0; at = -1; a = '0; rw = 1'b0; wd = '0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (mem_en) begin
            ok = 1; at = cyc; a = mem_addr; rw = mem_rd_wr; wd = mem_wdata;
            break;
         end
      end
      chk("mem_en_seen", 32'(ok), 32'd1);
   endtask

   task automatic wait_ready(input bit is_d, input int budget, output int at,
                             output logic [DW-1:0] rd, output logic e);
      bit ok;
      ok = 0; at = -1; rd = '0; e = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (is_d ? d_ready : i_ready) begin
            ok = 1; at = cyc; rd = is_d ? d_rdata : i_rdata; e = err;
            break;
         end
      end
      chk(is_d ? "d_ready_seen" : "i_ready_seen", 32'(ok), 32'd1);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Directed scenarios.
   initial begin
      int en_c, rd_c, g, cnt;
      logic [AW-1:0] a;
      logic rw, e;
      logic [DW-1:0] wd, rd;
      logic [9:0] seq;

      // reset
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      tick();
      resetn = 1'b1;

      // no grants until memory is loaded
      i_addr = 32'h500; i_req = 1'b1; mem_lat = 1; mem_data = 32'h11112222;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (mem_en) cnt++;
      end
      chk("pd_low_no_en", 32'(cnt), 32'd0);
      tick();
      programming_done = 1'b1;
      g = cyc;
      wait_en(5, en_c, a, rw, wd);
      chk("pd_en_latency", 32'(en_c - g), 32'd1);
      chk("pd_en_addr", a, 32'h500);
      wait_ready(0, 10, rd_c, rd, e);
      chk("pd_i_rdata", rd, 32'h11112222);
      tick();
      i_req = 1'b0;

      // single fetch, memory answers 3 cycles after mem_en
      tick();
      mem_lat = 3; mem_data = 32'hDEADBEEF; i_addr = 32'h100; i_req = 1'b1;
      wait_en(5, en_c, a, rw, wd);
      chk("fetch_addr", a, 32'h100);
      chk("fetch_rd_wr", 32'(rw), 32'd0);
      wait_ready(0, 10, rd_c, rd, e);
      chk("fetch_rdata", rd, 32'hDEADBEEF);
      chk("fetch_err", 32'(e), 32'd0);
      chk("fetch_latency", 32'(rd_c - en_c), 32'd4);
      tick();
      i_req = 1'b0;
      @(negedge clk);
      chk("fetch_ready_one_cycle", 32'(i_ready), 32'd0);

      // both requesting, 1-cycle memory: starvation limit forces every 5th
      tick();
      glog.delete();
      mem_lat = 0; mem_data = 32'h0BADF00D;
      i_addr = 32'h1000; d_addr = 32'h2000; d_rd_wr = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      cnt = 0;
      for (int k = 0; k < 200 && cnt < 10; k++) begin
         @(negedge clk);
         if (i_ready || d_ready) cnt++;
      end
      chk("arb_completions", 32'(cnt), 32'd10);
      tick();
      i_req = 1'b0; d_req = 1'b0;
      chk("arb_grant_count", 32'(glog.size()), 32'd10);
      seq = '0;
      for (int k = 0; k < 10 && k < glog.size(); k++) seq[9-k] = glog[k];
      chk("arb_grant_order", 32'(seq), 32'(10'b1111011110));

      // data write
      tick();
      mem_lat = 2; mem_data = 32'hA5A5A5A5;
      d_addr = 32'h40; d_wdata = 32'h55AA; d_rd_wr = 1'b1; d_req = 1'b1;
      wait_en(5, en_c, a, rw, wd);
      chk("wr_rd_wr", 32'(rw), 32'd1);
      chk("wr_addr", a, 32'h40);
      chk("wr_wdata", wd, 32'h55AA);
      wait_ready(1, 10, rd_c, rd, e);
      chk("wr_d_rdata", rd, 32'd0);
      chk("wr_err", 32'(e), 32'd0);
      tick();
      d_req = 1'b0; d_rd_wr = 1'b0;

      // memory never answers: timeout completion
      tick();
      mem_lat = -1; d_addr = 32'h80; d_req = 1'b1;
      wait_en(5, en_c, a, rw, wd);
      wait_ready(1, TO + 50, rd_c, rd, e);
      chk("tmo_latency", 32'(rd_c - en_c), 32'd256);
      chk("tmo_err", 32'(e), 32'd1);
      chk("tmo_d_rdata", rd, 32'd0);
      tick();
      d_req = 1'b0;

      // reset in the middle of a data wait, then a stray mem_ready
      tick();
      mem_lat = -1; d_addr = 32'h90; d_req = 1'b1;
      wait_en(5, en_c, a, rw, wd);
      repeat (2) @(negedge clk);
      chk("busy_in_wait", 32'(busy), 32'd1);
      tick();
      resetn = 1'b0; d_req = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_addr", mem_addr, 32'd0);
      tick();
      resetn = 1'b1;
      tick();
      mem_rdy_man = 1'b1; mem_rdata = 32'hBAD0BAD0;
      tick();
      mem_rdy_man = 1'b0;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (d_ready || i_ready || busy) cnt++;
      end
      chk("post_rst_quiet", 32'(cnt), 32'd0);
      tick();
      mem_lat = 1; mem_data = 32'hCAFEF00D; i_addr = 32'h300; i_req = 1'b1;
      wait_en(5, en_c, a, rw, wd);
      chk("post_rst_addr", a, 32'h300);
      wait_ready(0, 10, rd_c, rd, e);
      chk("post_rst_rdata", rd, 32'hCAFEF00D);
      chk("post_rst_latency", 32'(rd_c - en_c), 32'd2);
      tick();
      i_req = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
